// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit.
//   OP_MULT / OP_DIV : encodings of the op input sampled with start
//   ITER_COUNT       : one iteration per operand bit (default operand width)
//   state_t          : control FSM states
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring signed divider datapath: magnitude conversion at load, one
// shift/trial-subtract step per enabled clock, sign fixup on the outputs.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture operands and signs
//   step       : perform one restoring iteration
//   a, b       : dividend, divisor (two's complement)
//   quo, rem   : sign-corrected quotient / remainder (valid after WIDTH steps)
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH:0]   r;      // partial remainder
  logic [WIDTH-1:0] q;      // dividend bits shifting out, quotient bits in
  logic [WIDTH:0]   dvs;    // |b| with a zero sign bit, so |MIN| is exact
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] r_sh, trial;

  // Unsigned reading of -MIN is 2^(WIDTH-1), which is the exact magnitude.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  assign r_sh  = {r, q[WIDTH-1]};
  assign trial = r_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      q      <= '0;
      dvs    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (load) begin
      r      <= '0;
      q      <= a_mag;
      dvs    <= {1'b0, b_mag};
      sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
      sign_r <= a[WIDTH-1];
    end else if (step) begin
      if (!trial[WIDTH+1]) begin
        r <= trial[WIDTH:0];
        q <= {q[WIDTH-2:0], 1'b1};
      end else begin
        r <= r_sh[WIDTH:0];
        q <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // MIN / -1 wraps back to MIN here with no flag.
  assign quo = sign_q ? -q : q;
  assign rem = sign_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// producing HI/LO. One iteration per clock, start/busy/done handshake.
//   clk, reset    : clock, synchronous active-high reset
//   start, op     : request pulse (accepted only in IDLE), 0=MULT 1=DIV
//   src_a, src_b  : multiplicand/dividend, multiplier/divisor
//   busy          : operation in progress
//   done          : one-cycle pulse, hi/lo valid
//   div_zero      : one-cycle pulse with done on DIV by zero
//   hi, lo        : MULT product high/low, DIV remainder/quotient
// Optional: define MULTDIV_DIV_ZERO_TRAP_EN to short-circuit DIV by zero
// (no hi/lo write, div_zero flagged); otherwise div_zero is tied low and a
// zero divisor runs the normal iterations.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             accept, last, trap, finish, running;

  // Booth register {acc, mq, q_m1}; acc carries an extra bit so that
  // subtracting a most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc, acc_sum, mcand;
  logic [WIDTH-1:0] mq;
  logic             q_m1;

  logic [WIDTH-1:0] quo, rem;

  assign accept  = (state == S_IDLE) && start;
  assign last    = (cnt == '0);
  assign running = (state == S_MULT) || (state == S_DIV);
  assign finish  = running && last && !trap;

`ifdef MULTDIV_DIV_ZERO_TRAP_EN
  logic dz;

  always_ff @(posedge clk) begin
    if (reset)       dz <= 1'b0;
    else if (accept) dz <= (op == OP_DIV) && (src_b == '0);
  end

  assign trap = (state == S_DIV) && dz;

  always_ff @(posedge clk) begin
    if (reset) div_zero <= 1'b0;
    else       div_zero <= trap;
  end
`else
  assign trap     = 1'b0;
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (op == OP_DIV) ? S_DIV : S_MULT;
      S_MULT:  if (last) state_nx = S_DONE;
      S_DIV:   if (last || trap) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_MULT) || (state_nx == S_DIV);
      done  <= (state_nx == S_DONE);
      if (accept)       cnt <= CNT_LOAD;
      else if (running) cnt <= (last || trap) ? '0 : cnt - 1'b1;
    end
  end

  always_comb begin
    case ({mq[0], q_m1})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mq    <= '0;
      q_m1  <= 1'b0;
      mcand <= '0;
    end else if (accept) begin
      acc   <= '0;
      mq    <= src_b;
      q_m1  <= 1'b0;
      mcand <= {src_a[WIDTH-1], src_a};
    end else if ((state == S_MULT) && !last) begin
      {acc, mq, q_m1} <= {acc_sum[WIDTH], acc_sum, mq};
    end
  end

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  ((state == S_DIV) && !last),
    .a     (src_a),
    .b     (src_b),
    .quo   (quo),
    .rem   (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (state == S_MULT) begin
        hi <= acc[WIDTH-1:0];
        lo <= mq;
      end else begin
        hi <= rem;
        lo <= quo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk, reset, start, op;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, done, div_zero;

  int          tests, fails;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Signed MULT product, or {remainder, quotient} with truncating division.
  function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 1'b0) return 64'(sa * sb);
    if (b == 32'd0) begin
      // all-ones quotient magnitude, sign follows the dividend
      if (sa < 0) q = 1;
      else        q = 64'h0000_0000_FFFF_FFFF;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation. ign_at: sample index at which a stray start is
  // driven. rst_at: sample index at which reset is applied (aborts op).
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int ign_at, input int rst_at, input string tag);
    logic [63:0] e;
    int          n, bc, want;
    bit          trapped, stable;
    trapped = 1'b0;
`ifdef MULTDIV_DIV_ZERO_TRAP_EN
    trapped = (o == 1'b1) && (b == 32'd0);
`endif
    e    = trapped ? {exp_hi, exp_lo} : model(o, a, b);
    want = trapped ? 1 : 33;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    n = 0; bc = 0; stable = 1'b1;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (hi !== exp_hi || lo !== exp_lo) stable = 1'b0;
      if (n == ign_at) begin
        start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
      end
      if (n == rst_at) reset = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n - 1 == rst_at) begin
        reset = 1'b0;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_hilo"}, {hi, lo}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        return;
      end
    end
    chk({tag, "_latency"}, n, want);
    chk({tag, "_busy_cycles"}, bc, want);
    chk({tag, "_hilo_hold"}, stable, 1);
    chk({tag, "_div_zero"}, div_zero, trapped);
    chk({tag, "_hilo"}, {hi, lo}, e);
    exp_hi = e[63:32]; exp_lo = e[31:0];
    // start in the DONE cycle must be ignored
    start = 1'b1; op = 1'b0; src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, {done, div_zero, busy}, 3'b000);
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_hi = '0; exp_lo = '0;
    reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, done, div_zero}, 3'b000);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 32'd7,         32'hFFFF_FFFD, -1, -1, "mul_7_m3");
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1, "mul_min_min");
    do_op(1'b0, 32'h7FFF_FFFF, 32'd2,         -1, -1, "mul_max_2");
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2,         -1, -1, "div_m7_2");
    do_op(1'b1, 32'd100,       32'd7,         -1, -1, "div_100_7");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "div_min_m1");
    do_op(1'b1, 32'd12345,     32'd0,         -1, -1, "div_by_zero");
    do_op(1'b1, 32'hFFFF_FF00, 32'd0,         -1, -1, "div_neg_by_zero");
    do_op(1'b0, 32'd1234,      32'hFFFF_0001,  9, -1, "mul_ignore_start");
    do_op(1'b1, 32'd999,       32'd13,        -1, 14, "div_reset_mid");
    do_op(1'b1, 32'd999,       32'd13,        -1, -1, "div_after_reset");

    for (int i = 0; i < 24; i++) begin
      logic        o;
      logic [31:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      do_op(o, a, b, -1, -1, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
